// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes; one GROUP-bit slice per stage.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN (otherwise ovf is tied to 0).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LAT = WIDTH / GROUP;

  // Returns {carry into group MSB, carry out of group, group sum bits}.
  function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             c);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   cc;
    p     = x ^ y;
    g     = x & y;
    cc[0] = c;
    for (int i = 0; i < GROUP; i++) begin
      cc[i+1] = g[i] | (p[i] & cc[i]);
    end
    return {cc[GROUP-1], cc[GROUP], p ^ cc[GROUP-1:0]};
  endfunction

  logic [LAT-1:0]   vld_r;
  logic [LAT-1:0]   cry_r;
  logic [WIDTH-1:0] a_r    [LAT];
  logic [WIDTH-1:0] b_r    [LAT];
  logic [WIDTH-1:0] part_r [LAT];

  logic [LAT-1:0]   st_v;
  logic [LAT-1:0]   st_c;
  logic [WIDTH-1:0] st_a    [LAT];
  logic [WIDTH-1:0] st_b    [LAT];
  logic [WIDTH-1:0] st_part [LAT];

  logic [GROUP+1:0] grp     [LAT];
  logic [WIDTH-1:0] nx_part [LAT];
  logic [LAT-1:0]   nx_c;

  logic stall;

  assign out_valid = vld_r[LAT-1];
  assign sum       = part_r[LAT-1];
  assign cout      = cry_r[LAT-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Stage 0 sees the ports (B pre-inverted for subtract); later stages see the previous stage register.
  always_comb begin
    st_v       = '0;
    st_c       = '0;
    st_a[0]    = a;
    st_b[0]    = sub ? ~b : b;
    st_c[0]    = sub | cin;
    st_part[0] = '0;
    st_v[0]    = in_valid;
    for (int k = 1; k < LAT; k++) begin
      st_a[k]    = a_r[k-1];
      st_b[k]    = b_r[k-1];
      st_c[k]    = cry_r[k-1];
      st_part[k] = part_r[k-1];
      st_v[k]    = vld_r[k-1];
    end
  end

  // Each stage resolves its own group and merges it into the forwarded partial sum.
  always_comb begin
    nx_c = '0;
    for (int k = 0; k < LAT; k++) begin
      grp[k]     = cla_group(st_a[k][k*GROUP +: GROUP], st_b[k][k*GROUP +: GROUP], st_c[k]);
      nx_part[k] = st_part[k];
      nx_part[k][k*GROUP +: GROUP] = grp[k][GROUP-1:0];
      nx_c[k]    = grp[k][GROUP];
    end
  end

  // Whole pipeline, skew registers included, advances together and freezes on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      cry_r <= '0;
      for (int k = 0; k < LAT; k++) begin
        a_r[k]    <= '0;
        b_r[k]    <= '0;
        part_r[k] <= '0;
      end
    end else if (!stall) begin
      vld_r <= st_v;
      cry_r <= nx_c;
      for (int k = 0; k < LAT; k++) begin
        a_r[k]    <= st_a[k];
        b_r[k]    <= st_b[k];
        part_r[k] <= nx_part[k];
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_r;

  // Overflow is formed in the last stage and registered alongside cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (!stall) begin
      ovf_r <= grp[LAT-1][GROUP+1] ^ grp[LAT-1][GROUP];
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors, stall/flush scenarios and random traffic.
module tb_cla_pipe_adder;

  localparam int W   = 16;
  localparam int G   = 4;
  localparam int LAT = W / G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];

  cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   t;
    exp_t         e;
    yy  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s | c)};
    e.s = t[W-1:0];
    e.c = t[W];
`ifdef CLA_PIPE_OVF_EN
    e.o = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
`else
    e.o = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", {16'd0, sum}, {16'd0, e.s});
          check("cout", {31'd0, cout}, {31'd0, e.c});
          check("ovf", {31'd0, ovf}, {31'd0, e.o});
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    int n;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 1000) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [W-1:0] dir_a [7] = '{16'h0001, 16'h0001, 16'h0000, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
  logic [W-1:0] dir_b [7] = '{16'h0001, 16'hFFFF, 16'h0005, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
  logic         dir_c [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic         dir_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [W-1:0] frozen;
    int           n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;

    // Latency: out_valid rises exactly LAT cycles after the beat is presented.
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check("latency_out_valid", {31'd0, out_valid}, (i == LAT) ? 32'd1 : 32'd0);
    end
    idle(LAT + 2);

    // Directed vectors from the carry/subtract/overflow corner cases.
    for (int i = 0; i < 7; i++) drive(dir_a[i], dir_b[i], dir_c[i], dir_s[i]);
    idle(LAT + 4);

    // Eight back-to-back beats produce eight consecutive valid outputs.
    fork
      begin
        for (int i = 0; i < 8; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
          check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
          @(negedge clk);
        end
        check("b2b_after_stream", {31'd0, out_valid}, 32'd0);
      end
    join
    idle(LAT + 2);

    // Three-cycle stall in the middle of a stream freezes the output.
    fork
      begin
        for (int i = 0; i < 10; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        frozen = sum;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_sum_frozen", {16'd0, sum}, {16'd0, frozen});
          check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(LAT + 4);

    // Reset with three beats in flight discards them.
    for (int i = 0; i < 3; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_sum", {16'd0, sum}, 32'd0);
    n = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("flush_no_stale", n, 32'd0);
    @(posedge clk);
    #1;

    // Random traffic with random bubbles and backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 700; i++) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;

    n = 0;
    while (q.size() != 0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
